// File: rtl/pipe_out_pkg.sv
// ----------------------------------------------------------------------------
// pipe_out_pkg
// Shared constants and helpers for the output-pipe FIFO (pipe_out_fifo) and
// its storage RAM (pipe_out_ram).
//   DATA_W              : width of every word moved through the pipe
//   DEF_DEPTH           : default FIFO capacity in words
//   DEF_BLOCK_WORDS     : default fill level at which block_ready asserts
//   DEF_AF_MARGIN       : default free-slot margin for almost_full
//   ptr_w()             : pointer width for a given depth
//   is_pow2()           : power-of-two test used by the parameter checks
// ----------------------------------------------------------------------------
package pipe_out_pkg;

    localparam int DATA_W          = 32;
    localparam int DEF_DEPTH       = 512;
    localparam int DEF_BLOCK_WORDS = 256;
    localparam int DEF_AF_MARGIN   = 4;

    localparam int MIN_DEPTH       = 4;
    localparam int MAX_DEPTH       = 4096;

    // Address bits needed to index a storage array of 'depth' words.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // True when 'value' is a positive power of two.
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage : pipe_out_pkg

// File: rtl/pipe_out_ram.sv
// ----------------------------------------------------------------------------
// pipe_out_ram
// Simple dual-port RAM: one synchronous write port and one synchronous read
// port with a single cycle of read latency. No reset on storage or on the
// read register, so the array maps onto block RAM.
// The read register only updates when re_i is high, so rdata_o holds the
// last word read until the next read strobe.
// When the same address is written and read in one cycle the read returns
// the old contents (read-first); the FIFO relies on this when it is full and
// a write and a pop hit the same slot together.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable
//   raddr_i  : read address
//   rdata_o  : registered read data
// ----------------------------------------------------------------------------
module pipe_out_ram
    import pipe_out_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEF_DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : pipe_out_ram

// File: rtl/pipe_out_fifo.sv
// ----------------------------------------------------------------------------
// pipe_out_fifo
// Single-clock FIFO that buffers user words for a host output-pipe endpoint.
// The user side pushes with wr_en; the endpoint pops with ep_read and sees
// the popped word on ep_datain one cycle later. Status flags decode from the
// registered word count; overflow/underflow are sticky until clr_flags.
// Ports:
//   okClk       : clock for all logic
//   rst_n       : asynchronous active-low reset
//   wr_en       : user write strobe
//   wr_data     : user write word
//   full        : no free slot
//   almost_full : free slots <= AF_MARGIN
//   ep_read     : endpoint pop request
//   ep_datain   : word returned to the endpoint (one cycle after the pop)
//   empty       : no stored word
//   count       : stored word count
//   block_ready : count >= BLOCK_WORDS
//   overflow    : sticky, a write was dropped
//   underflow   : sticky, a read hit an empty FIFO
//   clr_flags   : synchronous clear of overflow and underflow
// ----------------------------------------------------------------------------
module pipe_out_fifo
    import pipe_out_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int AF_MARGIN   = DEF_AF_MARGIN
) (
    input  logic                      okClk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      full,
    output logic                      almost_full,
    input  logic                      ep_read,
    output logic [DATA_W-1:0]         ep_datain,
    output logic                      empty,
    output logic [ptr_w(DEPTH):0]     count,
    output logic                      block_ready,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_flags
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!is_pow2(DEPTH) || DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $fatal(1, "pipe_out_fifo: DEPTH=%0d must be a power of two in %0d..%0d",
               DEPTH, MIN_DEPTH, MAX_DEPTH);
    end

    if (BLOCK_WORDS < 1 || BLOCK_WORDS > DEPTH) begin : g_bad_block
        $fatal(1, "pipe_out_fifo: BLOCK_WORDS=%0d must be in 1..DEPTH (%0d)",
               BLOCK_WORDS, DEPTH);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;
    // While set, ep_datain is forced to zero (after reset and after an
    // underflow read); cleared by the next real pop.
    logic          dout_zero_q, dout_zero_d;

    logic          full_w;
    logic          empty_w;
    logic          pop_w;
    logic          wr_acc_w;
    logic          ovf_evt_w;
    logic          udf_evt_w;
    logic [CW-1:0] free_w;
    logic [DATA_W-1:0] ram_rdata_w;

    // ------------------------------------------------------------------
    // Status decode from the registered count
    // ------------------------------------------------------------------
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);
    assign free_w  = DEPTH_C - count_q;

    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = count_q;
    assign almost_full = (32'(free_w) <= 32'(AF_MARGIN));
    assign block_ready = (32'(count_q) >= 32'(BLOCK_WORDS));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // ------------------------------------------------------------------
    // Transfer qualification
    // ------------------------------------------------------------------
    // A pop frees a slot in the same cycle, so a write against a full FIFO
    // is still accepted when paired with a pop.
    assign pop_w     = ep_read & ~empty_w;
    assign wr_acc_w  = wr_en & (~full_w | pop_w);
    assign ovf_evt_w = wr_en & full_w & ~pop_w;
    assign udf_evt_w = ep_read & empty_w;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_zero_d = dout_zero_q;

        // Pointer width equals log2(DEPTH), so the increment wraps by itself.
        if (wr_acc_w) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_acc_w, pop_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop_w) begin
            dout_zero_d = 1'b0;
        end else if (udf_evt_w) begin
            dout_zero_d = 1'b1;
        end

        // Clear first, then let a same-cycle event re-set the flag.
        overflow_d  = (overflow_q  & ~clr_flags) | ovf_evt_w;
        underflow_d = (underflow_q & ~clr_flags) | udf_evt_w;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_zero_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_zero_q <= dout_zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // The RAM read register is the output register: it loads only on a pop
    // and holds its value otherwise. Reset and underflow are expressed by
    // masking it with dout_zero_q, keeping the RAM itself reset-free.
    pipe_out_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (okClk),
        .we_i    (wr_acc_w),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (pop_w),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata_w)
    );

    assign ep_datain = dout_zero_q ? '0 : ram_rdata_w;

endmodule : pipe_out_fifo

// File: tb/tb_pipe_out_fifo.sv
module tb_pipe_out_fifo;

    localparam int DEPTH       = 8;
    localparam int BLOCK_WORDS = 4;
    localparam int AF_MARGIN   = 2;

    logic        okClk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        almost_full;
    logic        ep_read;
    logic [31:0] ep_datain;
    logic        empty;
    logic [3:0]  count;
    logic        block_ready;
    logic        overflow;
    logic        underflow;
    logic        clr_flags;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q [$];
    logic [31:0] exp_word;

    always #5 okClk = ~okClk;

    pipe_out_fifo #(
        .DEPTH       (DEPTH),
        .BLOCK_WORDS (BLOCK_WORDS),
        .AF_MARGIN   (AF_MARGIN)
    ) dut (
        .okClk       (okClk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .ep_read     (ep_read),
        .ep_datain   (ep_datain),
        .empty       (empty),
        .count       (count),
        .block_ready (block_ready),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_flags   (clr_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] c, input logic e,
                             input logic f, input logic af, input logic br);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"},  32'(full),  32'(f));
        chk({tag, ".af"},    32'(almost_full), 32'(af));
        chk({tag, ".br"},    32'(block_ready), 32'(br));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        ep_read   = 1'b0;
        clr_flags = 1'b0;

        // Reset state
        tick();
        tick();
        chk_flags("rst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst.dout", ep_datain, 32'h0);
        chk("rst.ovf",  32'(overflow),  32'h0);
        chk("rst.udf",  32'(underflow), 32'h0);
        rst_n = 1'b1;

        // Read on empty: zero data, sticky underflow, then clear
        ep_read = 1'b1;
        tick();
        ep_read = 1'b0;
        chk("udf.dout", ep_datain, 32'h0);
        chk("udf.flag", 32'(underflow), 32'h1);
        chk("udf.count", 32'(count), 32'h0);
        tick();
        chk("udf.sticky", 32'(underflow), 32'h1);
        // Clear together with a new underflow: set wins
        clr_flags = 1'b1;
        ep_read   = 1'b1;
        tick();
        chk("udf.setwins", 32'(underflow), 32'h1);
        ep_read = 1'b0;
        tick();
        clr_flags = 1'b0;
        chk("udf.clr", 32'(underflow), 32'h0);

        // Write 1..4, then pop 4
        for (int i = 1; i <= 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'(i);
            tick();
            chk("wr4.count", 32'(count), 32'(i));
        end
        wr_en = 1'b0;
        chk_flags("wr4", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        ep_read = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rd4.dout",  ep_datain, 32'(i));
            chk("rd4.count", 32'(count), 32'(4 - i));
        end
        ep_read = 1'b0;
        tick();
        chk("rd4.hold", ep_datain, 32'h4);
        chk_flags("rd4", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill past full: A0..A8, ninth dropped
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'hA0 + 32'(i);
            tick();
            if (i == 7) begin
                chk_flags("fill8", 4'd8, 1'b0, 1'b1, 1'b1, 1'b1);
                chk("fill8.ovf", 32'(overflow), 32'h0);
            end
        end
        wr_en = 1'b0;
        chk("ovf.flag",  32'(overflow), 32'h1);
        chk("ovf.count", 32'(count), 32'h8);
        ep_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ovfrd.dout", ep_datain, 32'hA0 + 32'(i));
        end
        ep_read = 1'b0;
        chk("ovfrd.empty", 32'(empty), 32'h1);
        tick();
        chk("ovfrd.hold", ep_datain, 32'hA7);
        chk("ovfrd.udf", 32'(underflow), 32'h0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovf.clr", 32'(overflow), 32'h0);

        // Write on empty with a same-cycle read: write kept, underflow set
        wr_en   = 1'b1;
        wr_data = 32'hF0;
        ep_read = 1'b1;
        tick();
        wr_en   = 1'b0;
        chk("wre.count", 32'(count), 32'h1);
        chk("wre.udf",   32'(underflow), 32'h1);
        chk("wre.dout",  ep_datain, 32'h0);
        tick();
        ep_read = 1'b0;
        chk("wre.rd",    ep_datain, 32'hF0);
        chk("wre.empty", 32'(empty), 32'h1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // Fill B0..B7, then write+read while full, then stream 20 words
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'hB0 + 32'(i);
            model_q.push_back(32'hB0 + 32'(i));
            tick();
        end
        chk("b.full", 32'(full), 32'h1);
        wr_data = 32'hB8;
        ep_read = 1'b1;
        model_q.push_back(32'hB8);
        exp_word = model_q.pop_front();
        tick();
        chk("wrfull.dout",  ep_datain, exp_word);
        chk("wrfull.count", 32'(count), 32'h8);
        chk("wrfull.ovf",   32'(overflow), 32'h0);
        for (int i = 0; i < 20; i++) begin
            wr_data = 32'hC0 + 32'(i);
            model_q.push_back(32'hC0 + 32'(i));
            exp_word = model_q.pop_front();
            tick();
            chk("stream.dout", ep_datain, exp_word);
            chk("stream.count", 32'(count), 32'h8);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_word = model_q.pop_front();
            tick();
            chk("drain.dout", ep_datain, exp_word);
        end
        ep_read = 1'b0;
        chk("drain.dlast", ep_datain, 32'hD3);
        chk("drain.empty", 32'(empty), 32'h1);
        chk("drain.ovf",   32'(overflow), 32'h0);
        chk("drain.udf",   32'(underflow), 32'h0);

        // Fill 6: block_ready from 4, almost_full from 6
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'hD0 + 32'(i);
            tick();
            chk("thr.br", 32'(block_ready), (i >= 3) ? 32'h1 : 32'h0);
            chk("thr.af", 32'(almost_full), (i >= 5) ? 32'h1 : 32'h0);
        end
        wr_en = 1'b0;
        chk_flags("thr6", 4'd6, 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle clears immediately
        ep_read = 1'b1;
        tick();
        chk("prerst.dout", ep_datain, 32'hD0);
        ep_read = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_flags("arst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("arst.dout", ep_datain, 32'h0);
        tick();
        rst_n = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'hE0;
        tick();
        wr_en   = 1'b0;
        chk("post.count", 32'(count), 32'h1);
        ep_read = 1'b1;
        tick();
        ep_read = 1'b0;
        chk("post.dout",  ep_datain, 32'hE0);
        chk("post.empty", 32'(empty), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_out_fifo

// File: doc/pipe_out_fifo.md
PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

Interface
REQ-001 Parameter DEPTH, default 512; FIFO capacity in 32-bit words; power of two, 4..4096.
REQ-002 Parameter BLOCK_WORDS, default 256; threshold for block_ready; 1..DEPTH.
REQ-003 Parameter AF_MARGIN, default 4; almost_full asserts when free slots <= AF_MARGIN.
REQ-004 Port okClk, input, 1, single clock for all logic; host-interface clock.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port wr_en, input, 1, user write strobe.
REQ-007 Port wr_data, input, 32, user write word.
REQ-008 Port full, output, 1, no free slot.
REQ-009 Port almost_full, output, 1, free slots <= AF_MARGIN.
REQ-010 Port ep_read, input, 1, pop request from the output-pipe endpoint.
REQ-011 Port ep_datain, output, 32, word returned to the output-pipe endpoint.
REQ-012 Port empty, output, 1, no stored word.
REQ-013 Port count, output, log2(DEPTH)+1, stored word count.
REQ-014 Port block_ready, output, 1, count >= BLOCK_WORDS.
REQ-015 Port overflow, output, 1, sticky; a write was dropped.
REQ-016 Port underflow, output, 1, sticky; a read hit an empty FIFO.
REQ-017 Port clr_flags, input, 1, synchronous clear of overflow and underflow.

Function
REQ-018 Write accepted when wr_en=1 and (full=0 or a pop occurs the same cycle); the word is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
REQ-019 Write with full=1 and no same-cycle pop is dropped; overflow sets on the next edge; pointers and count are unchanged.
REQ-020 Pop occurs when ep_read=1 and empty=0; rd_ptr increments, wrapping modulo DEPTH.
REQ-021 Read latency is exactly 1 cycle: ep_datain is registered and on the edge after a pop it holds the popped word; it holds that value until the next pop.
REQ-022 ep_read=1 with empty=1: no pop; ep_datain loads 32'h0 on the next edge; underflow sets; a same-cycle write is still accepted.
REQ-023 count updates registered: +1 on write only, -1 on pop only, unchanged on write+pop or on neither.
REQ-024 full, empty, almost_full and block_ready decode combinationally from registered count: full = (count==DEPTH), empty = (count==0).
REQ-025 Pointers are log2(DEPTH) bits; wrap-around is implicit in the bit width; count never exceeds DEPTH and never underflows.
REQ-026 clr_flags=1 clears both sticky flags on the next edge; if a new overflow or underflow event occurs in the same cycle, the flag stays set (set wins).
REQ-027 Word order out equals word order in; no word is duplicated or lost, except those dropped per REQ-019.

Reset
REQ-028 When rst_n=0, asynchronously: wr_ptr=0, rd_ptr=0, count=0, ep_datain=32'h0, overflow=0, underflow=0; hence empty=1, full=0, almost_full=0, block_ready=0.
REQ-029 Reset mid-transfer discards all stored data; storage-array contents are not reset.
REQ-030 Synchronous operation resumes on the first okClk rising edge after rst_n deasserts.

Structure
REQ-031 Shared package pipe_out_pkg holds: DATA_W=32, the default DEPTH/BLOCK_WORDS/AF_MARGIN values, and a clog2-based pointer-width function.
REQ-032 One sub-module, pipe_out_ram: simple dual-port RAM, DATA_W x DEPTH, synchronous write, synchronous read with 1-cycle latency, no reset; the FIFO controller instantiates it once.
REQ-033 A parameter violation (non-power-of-two DEPTH, or BLOCK_WORDS outside 1..DEPTH) raises a simulation-time error and finish.

Verification
REQ-034 After reset, write 0x1..0x4 on 4 consecutive cycles, then pulse ep_read 4 cycles -> ep_datain = 0x1,0x2,0x3,0x4, each one cycle after its pop; empty=1 afterwards; count sequence 4,3,2,1,0.
REQ-035 DEPTH=8: write 9 words 0xA0..0xA8 with no reads -> full=1 after the 8th; 9th dropped, overflow=1; readback yields 0xA0..0xA7 only.
REQ-036 ep_read on empty after reset -> ep_datain=0, underflow=1; clr_flags pulse -> underflow=0 the next cycle.
REQ-037 DEPTH=8, FIFO full: wr_en and ep_read in the same cycle -> write accepted, count stays 8, no overflow; then stream 20 words with continuous write+read -> pointers wrap, output order preserved.
REQ-038 BLOCK_WORDS=4, AF_MARGIN=2, DEPTH=8: fill 6 words -> block_ready=1 from count 4, almost_full=1 from count 6; assert rst_n=0 mid-stream -> all flags/count clear immediately, no earlier data appears after reset.
